// File: rtl/axi2ahb_rd_fifo.sv
// Read-return buffer of the AXI-to-AHB bridge: captures AHB read beats and replays them
// as AXI R-channel beats, while tracking space already promised to issued bursts.
module axi2ahb_rd_fifo #(
    parameter int         DATA_BITS   = 32,
    parameter int         ID_BITS     = 4,
    parameter int         FIFO_LINES  = 32,
    parameter int         MAX_BURST   = 16,
    parameter logic [1:0] RESP_SLVERR = 2'b10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    input  logic                 cmd_start,
    input  logic [3:0]           cmd_len,
    input  logic                 rdata_phase,
    input  logic                 data_last,
    input  logic [ID_BITS-1:0]   cmd_id,
    input  logic                 cmd_err,
    output logic                 rdata_ready,
    output logic [ID_BITS-1:0]   RID,
    output logic [DATA_BITS-1:0] RDATA,
    output logic [1:0]           RRESP,
    output logic                 RLAST,
    output logic                 RVALID,
    input  logic                 RREADY
);
    localparam int PTR_BITS   = $clog2(FIFO_LINES);
    localparam int CNT_BITS   = PTR_BITS + 1;
    localparam int ENTRY_BITS = ID_BITS + DATA_BITS + 3;

    logic [ENTRY_BITS-1:0] mem [FIFO_LINES];
    logic [PTR_BITS-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_BITS-1:0]   used_reg, reserved_reg, reserved_next;
    logic [CNT_BITS:0]     reserve_sum;
    logic [CNT_BITS:0]     total;
    logic                  full, empty, beat, push, pop;
    logic [1:0]            resp;

    assign full  = (used_reg == CNT_BITS'(FIFO_LINES));
    assign empty = (used_reg == '0);
    // A beat on the bus always consumes its reservation, even if it has to be dropped.
    assign beat  = rdata_phase & HREADY;
    assign push  = beat & ~full;
    assign pop   = ~empty & RREADY;
    assign resp  = (cmd_err | HRESP) ? RESP_SLVERR : 2'b00;

    function automatic logic [PTR_BITS-1:0] ptr_inc(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(FIFO_LINES - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {cmd_id, HRDATA, resp, data_last};
        end
    end

    always_comb begin
        reserve_sum = {1'b0, reserved_reg};
        if (cmd_start) begin
            reserve_sum = reserve_sum + (CNT_BITS + 1)'(cmd_len) + 1'b1;
        end
        // Saturate at zero for beats that arrive without a matching reservation.
        if (beat && (reserve_sum != '0)) begin
            reserve_sum = reserve_sum - 1'b1;
        end
        reserved_next = reserve_sum[CNT_BITS-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            used_reg     <= '0;
            reserved_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            if (push && !pop) begin
                used_reg <= used_reg + 1'b1;
            end else if (pop && !push) begin
                used_reg <= used_reg - 1'b1;
            end
            reserved_reg <= reserved_next;
        end
    end

    assign total       = {1'b0, used_reg} + {1'b0, reserved_reg};
    assign rdata_ready = (total <= (CNT_BITS + 1)'(FIFO_LINES - MAX_BURST));

    assign {RID, RDATA, RRESP, RLAST} = mem[rd_ptr_reg];
    assign RVALID = ~empty;
endmodule

// File: tb/tb_axi2ahb_rd_fifo.sv
// Directed bench for axi2ahb_rd_fifo: a queue-based model checked every cycle, plus
// literal expectations on the accepted R beats and on rdata_ready at key points.
module tb_axi2ahb_rd_fifo;
    localparam int LINES = 32;
    localparam int BURST = 16;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] HRDATA = '0;
    logic        HREADY = 1'b0;
    logic        HRESP = 1'b0;
    logic        cmd_start = 1'b0;
    logic [3:0]  cmd_len = '0;
    logic        rdata_phase = 1'b0;
    logic        data_last = 1'b0;
    logic [3:0]  cmd_id = '0;
    logic        cmd_err = 1'b0;
    logic        rdata_ready;
    logic [3:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;

    int checks = 0;
    int errors = 0;

    beat_t mq[$];
    int    mres = 0;
    beat_t acc[$];

    axi2ahb_rd_fifo dut (
        .clk(clk), .reset(reset), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .cmd_start(cmd_start), .cmd_len(cmd_len), .rdata_phase(rdata_phase),
        .data_last(data_last), .cmd_id(cmd_id), .cmd_err(cmd_err),
        .rdata_ready(rdata_ready), .RID(RID), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of beats and an integer reservation count.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            mres = 0;
        end else begin
            bit do_pop, do_push;
            beat_t b;
            do_pop  = (mq.size() > 0) && RREADY;
            do_push = rdata_phase && HREADY && (mq.size() < LINES);
            b.id   = cmd_id;
            b.data = HRDATA;
            b.resp = (cmd_err || HRESP) ? 2'b10 : 2'b00;
            b.last = data_last;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(b);
            if (cmd_start) mres += int'(cmd_len) + 1;
            if (rdata_phase && HREADY) mres -= 1;
            if (mres < 0) mres = 0;
        end
    end

    // Per-cycle compare; also logs every beat the AXI side will accept at the next edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!reset) begin
                chk("rvalid", RVALID, (mq.size() > 0));
                chk("rdata_ready", rdata_ready, ((mq.size() + mres) <= (LINES - BURST)));
                if (mq.size() > 0) begin
                    chk("rid", RID, mq[0].id);
                    chk("rdata", RDATA, mq[0].data);
                    chk("rresp", RRESP, mq[0].resp);
                    chk("rlast", RLAST, mq[0].last);
                end
                if (RVALID && RREADY) begin
                    beat_t o;
                    o.id = RID; o.data = RDATA; o.resp = RRESP; o.last = RLAST;
                    acc.push_back(o);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [3:0] len);
        cmd_start = 1'b1; cmd_len = len;
        step();
        cmd_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] id, input logic last,
                        input logic hresp, input logic err);
        rdata_phase = 1'b1; HREADY = 1'b1; HRDATA = d; cmd_id = id;
        data_last = last; HRESP = hresp; cmd_err = err;
        step();
        rdata_phase = 1'b0; HREADY = 1'b0; HRESP = 1'b0; cmd_err = 1'b0; data_last = 1'b0;
    endtask

    task automatic wait_beat();
        rdata_phase = 1'b1; HREADY = 1'b0; HRDATA = 32'hDEAD_BEEF;
        step();
        rdata_phase = 1'b0;
    endtask

    task automatic chk_acc(input string name, input int idx, input logic [31:0] d,
                           input logic [3:0] id, input logic [1:0] resp, input logic last);
        if (idx >= acc.size()) begin
            chk({name, "_missing"}, acc.size(), idx + 1);
        end else begin
            chk({name, "_data"}, acc[idx].data, d);
            chk({name, "_id"}, acc[idx].id, id);
            chk({name, "_resp"}, acc[idx].resp, resp);
            chk({name, "_last"}, acc[idx].last, last);
        end
    endtask

    initial begin
        repeat (2) step();
        chk("reset_rvalid", RVALID, 1'b0);
        chk("reset_ready", rdata_ready, 1'b1);
        reset = 1'b0;
        step();

        // Basic 4-beat burst streamed straight through.
        RREADY = 1'b1;
        cmd(4'd3);
        for (int i = 0; i < 4; i++) beat(32'hA0 + i, 4'd5, (i == 3), 1'b0, 1'b0);
        repeat (3) step();
        for (int i = 0; i < 4; i++) chk_acc("basic", i, 32'hA0 + i, 4'd5, 2'b00, (i == 3));
        chk("basic_ready", rdata_ready, 1'b1);
        acc.delete();

        // Two max bursts reserved, filled to full with RREADY low, then drained.
        RREADY = 1'b0;
        cmd(4'd15);
        chk("resv1_ready", rdata_ready, 1'b1);
        cmd(4'd15);
        chk("resv2_ready", rdata_ready, 1'b0);
        for (int i = 0; i < 32; i++) beat(i, 4'd1, (i % 16 == 15), 1'b0, 1'b0);
        beat(32'h55, 4'd2, 1'b0, 1'b0, 1'b0);
        chk("full_rvalid", RVALID, 1'b1);
        chk("full_ready", rdata_ready, 1'b0);
        RREADY = 1'b1;
        repeat (15) step();
        chk("pop15_ready", rdata_ready, 1'b0);
        step();
        chk("pop16_ready", rdata_ready, 1'b1);
        repeat (18) step();
        chk("drain_count", acc.size(), 32);
        chk_acc("drain0", 0, 32'd0, 4'd1, 2'b00, 1'b0);
        chk_acc("drain15", 15, 32'd15, 4'd1, 2'b00, 1'b1);
        chk_acc("drain31", 31, 32'd31, 4'd1, 2'b00, 1'b1);
        acc.delete();

        // Wait states inside a burst, with RREADY toggling.
        cmd(4'd3);
        for (int i = 0; i < 4; i++) begin
            RREADY = i[0];
            wait_beat();
            beat(32'hB0 + i, 4'd7, (i == 3), 1'b0, 1'b0);
            wait_beat();
        end
        RREADY = 1'b1;
        repeat (6) step();
        chk("wait_count", acc.size(), 4);
        for (int i = 0; i < 4; i++) chk_acc("wait", i, 32'hB0 + i, 4'd7, 2'b00, (i == 3));
        acc.delete();

        // HRESP on beat 2 of 4, then a burst fully flagged by cmd_err.
        cmd(4'd3);
        for (int i = 0; i < 4; i++) beat(32'hC0 + i, 4'd3, (i == 3), (i == 1), 1'b0);
        cmd(4'd1);
        for (int i = 0; i < 2; i++) beat(32'hD0 + i, 4'd9, (i == 1), 1'b0, 1'b1);
        repeat (4) step();
        chk_acc("hresp0", 0, 32'hC0, 4'd3, 2'b00, 1'b0);
        chk_acc("hresp1", 1, 32'hC1, 4'd3, 2'b10, 1'b0);
        chk_acc("hresp2", 2, 32'hC2, 4'd3, 2'b00, 1'b0);
        chk_acc("cmderr0", 4, 32'hD0, 4'd9, 2'b10, 1'b0);
        chk_acc("cmderr1", 5, 32'hD1, 4'd9, 2'b10, 1'b1);
        acc.delete();

        // Push and pop together at used=1; cmd_start len 0 alongside a push.
        RREADY = 1'b0;
        beat(32'hE0, 4'd4, 1'b0, 1'b0, 1'b0);
        RREADY = 1'b1;
        beat(32'hE1, 4'd4, 1'b0, 1'b0, 1'b0);
        chk("pp_rvalid", RVALID, 1'b1);
        chk("pp_head", RDATA, 32'hE1);
        RREADY = 1'b0;
        cmd_start = 1'b1; cmd_len = 4'd0;
        beat(32'hE2, 4'd4, 1'b1, 1'b0, 1'b0);
        cmd_start = 1'b0;
        RREADY = 1'b1;
        repeat (4) step();

        // Reset with 10 beats buffered, then a fresh burst.
        RREADY = 1'b0;
        cmd(4'd9);
        for (int i = 0; i < 10; i++) beat(32'hF0 + i, 4'd6, (i == 9), 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_rvalid", RVALID, 1'b0);
        chk("midrst_ready", rdata_ready, 1'b1);
        step();
        reset = 1'b0;
        acc.delete();
        RREADY = 1'b1;
        cmd(4'd1);
        beat(32'h1234, 4'd8, 1'b0, 1'b0, 1'b0);
        beat(32'h5678, 4'd8, 1'b1, 1'b0, 1'b0);
        repeat (3) step();
        chk("post_count", acc.size(), 2);
        chk_acc("post0", 0, 32'h1234, 4'd8, 2'b00, 1'b0);
        chk_acc("post1", 1, 32'h5678, 4'd8, 2'b00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
